// File: rtl/ieeedrv_pkg.sv
// Shared types and constants for the IEEE drive byte interface and track generator.
package ieeedrv_pkg;

  // Byte interface controller states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_WR_ARM = 2'd2,
    S_WR     = 2'd3
  } byteIfState_t;

  // GCR sync codes, shared with the track generator.
  localparam logic [7:0] HEADER_SYNC_CODE = 8'h08;
  localparam logic [7:0] DATA_SYNC_CODE   = 8'h07;
  localparam logic [7:0] TEST_SYNC_CODE   = 8'h0F;

  // True for the states in which the drive head writes.
  function automatic logic is_write_state(input byteIfState_t s);
    return (s == S_WR_ARM) || (s == S_WR);
  endfunction

endpackage

// File: rtl/ieeedrv_edge.sv
// Input flop plus falling-edge detector. The raw input is flopped once, and the
// previous flopped value is kept so a 1->0 transition yields a one-cycle pulse.
module ieeedrv_edge (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic fall
);

  logic din_q;
  logic din_hist;

  // Synchronising flop and one-deep history, both idle-high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      din_q    <= 1'b1;
      din_hist <= 1'b1;
    end else begin
      din_q    <= din;
      din_hist <= din_q;
    end
  end

  assign fall = din_hist & ~din_q;

endmodule

// File: rtl/ieeedrv_byte_if.sv
// Byte-level handshake between the track generator and the drive CPU port.
// Read mode latches each generated byte and signals it to the CPU; write mode
// double-buffers CPU bytes onto byte_wr/sync_wr at byte boundaries.
//
// Handshake: byte_rdy is the CPU-facing valid/ready flag. In read mode it means
// rd_data holds an unconsumed byte (valid); a one-cycle cpu_rd acknowledges it.
// In write mode it means the holding register is free (ready); a one-cycle cpu_wr
// fills it. A boundary arriving while the flag says "not consumed" (read) or
// "empty" (write) raises overrun or underrun respectively.
module ieeedrv_byte_if
  import ieeedrv_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int          SO_WIDTH  = 1
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         mtr,
  input  logic         mode_rd,
  input  logic         brdy_n,
  input  logic         sync_rd_n,
  input  logic [7:0]   byte_rd,
  input  logic         trk_err,
  output logic         rw,
  output logic         sync_wr,
  output logic [7:0]   byte_wr,
  input  logic [7:0]   cpu_din,
  input  logic         cpu_wr,
  input  logic         cpu_sync,
  input  logic         cpu_rd,
  output logic [7:0]   rd_data,
  output logic         byte_rdy,
  output logic         so_n,
  output logic         sync_det,
  output logic         overrun,
  output logic         underrun,
  output byteIfState_t state_dbg
);

  localparam logic [1:0] SO_LAST = 2'(SO_WIDTH - 1);

  byteIfState_t state;
  logic [1:0]   so_cnt;
  logic [7:0]   hold;
  logic         full;
  logic         bnd;
  logic         run;
  logic         mode_flip;
  logic         leave;
  logic         wr_take;
  logic         full_nxt;

  ieeedrv_edge u_brdy_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (brdy_n),
    .fall    (bnd)
  );

  // Qualifiers for leaving the active modes and for consuming the holding register.
  always_comb begin
    run       = mtr & ~trk_err;
    mode_flip = (state == S_RD) ? ~mode_rd : mode_rd;
    leave     = ~run | mode_flip;
    wr_take   = bnd & ((state == S_WR) | ((state == S_WR_ARM) & (full | cpu_sync)));
    full_nxt  = full;
    if (wr_take) full_nxt = 1'b0;
    if (cpu_wr)  full_nxt = 1'b1;
  end

  // Controller FSM with all registered outputs, SO pulse timer and write buffer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rw       <= 1'b1;
      sync_wr  <= 1'b0;
      byte_wr  <= FILL_BYTE;
      rd_data  <= 8'h00;
      byte_rdy <= 1'b0;
      so_n     <= 1'b1;
      so_cnt   <= 2'd0;
      sync_det <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      hold     <= 8'h00;
      full     <= 1'b0;
    end else begin
      // The SO pulse runs to completion regardless of state; a new trigger below restarts it.
      if (!so_n) begin
        if (so_cnt == 2'd0) so_n   <= 1'b1;
        else                so_cnt <= so_cnt - 2'd1;
      end

      if (state == S_IDLE) begin
        byte_rdy <= 1'b0;
        sync_det <= 1'b0;
        sync_wr  <= 1'b0;
        rw       <= 1'b1;
        if (run) begin
          if (mode_rd) begin
            state <= S_RD;
          end else begin
            state <= S_WR_ARM;
            rw    <= 1'b0;
          end
        end
      end else if (leave) begin
        // Motor off / track error keeps the sticky flags; a mode change clears them.
        state    <= S_IDLE;
        rw       <= 1'b1;
        sync_wr  <= 1'b0;
        byte_rdy <= 1'b0;
        sync_det <= 1'b0;
        if (run) begin
          overrun  <= 1'b0;
          underrun <= 1'b0;
          full     <= 1'b0;
        end
      end else if (state == S_RD) begin
        if (cpu_rd) byte_rdy <= 1'b0;
        if (bnd) begin
          rd_data  <= byte_rd;
          sync_det <= ~sync_rd_n;
          // Sync-field bytes are latched but not announced to the CPU.
          if (sync_rd_n) begin
            if (byte_rdy && !cpu_rd) overrun <= 1'b1;
            byte_rdy <= 1'b1;
            so_n     <= 1'b0;
            so_cnt   <= SO_LAST;
          end
        end
      end else begin
        if (wr_take) begin
          state   <= S_WR;
          sync_wr <= cpu_sync;
          if (full) begin
            byte_wr <= hold;
            so_n    <= 1'b0;
            so_cnt  <= SO_LAST;
          end else begin
            byte_wr <= FILL_BYTE;
            if (!cpu_sync) underrun <= 1'b1;
          end
        end
        // A load in the boundary cycle lands after the old byte has been taken.
        if (cpu_wr) hold <= cpu_din;
        full     <= full_nxt;
        byte_rdy <= ~full_nxt;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ieeedrv_byte_if.sv
// Bench for ieeedrv_byte_if: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the byte interface.
module tb_ieeedrv_byte_if;
  import ieeedrv_pkg::*;

  localparam logic [7:0] FILL     = 8'h00;
  localparam int         SO_WIDTH = 1;
  localparam int M_IDLE = 0, M_RD = 1, M_ARM = 2, M_WR = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk_sys, reset_n;
  logic mtr, mode_rd, brdy_n, sync_rd_n, trk_err;
  logic [7:0] byte_rd, cpu_din;
  logic cpu_wr, cpu_sync, cpu_rd;
  logic rw, sync_wr, byte_rdy, so_n, sync_det, overrun, underrun;
  logic [7:0] byte_wr, rd_data;
  byteIfState_t state_dbg;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ieeedrv_byte_if #(.FILL_BYTE(FILL), .SO_WIDTH(SO_WIDTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .mtr(mtr), .mode_rd(mode_rd),
    .brdy_n(brdy_n), .sync_rd_n(sync_rd_n), .byte_rd(byte_rd), .trk_err(trk_err),
    .rw(rw), .sync_wr(sync_wr), .byte_wr(byte_wr), .cpu_din(cpu_din),
    .cpu_wr(cpu_wr), .cpu_sync(cpu_sync), .cpu_rd(cpu_rd), .rd_data(rd_data),
    .byte_rdy(byte_rdy), .so_n(so_n), .sync_det(sync_det), .overrun(overrun),
    .underrun(underrun), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int so_falls = 0;
  logic so_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode;
  bit         m_prev1, m_prev2;
  logic [7:0] m_hold;
  bit         m_full;
  int         m_so_left;
  logic       e_rw, e_sync_wr, e_byte_rdy, e_sync_det, e_overrun, e_underrun;
  logic [7:0] e_byte_wr, e_rd_data;

  task automatic model_reset();
    m_mode = M_IDLE; m_prev1 = 1'b1; m_prev2 = 1'b1; m_hold = 8'h00; m_full = 1'b0;
    m_so_left = 0; e_rw = 1'b1; e_sync_wr = 1'b0; e_byte_wr = FILL; e_rd_data = 8'h00;
    e_byte_rdy = 1'b0; e_sync_det = 1'b0; e_overrun = 1'b0; e_underrun = 1'b0;
  endtask

  task automatic model_step();
    bit bnd, run, flip, take;
    bnd = m_prev2 && !m_prev1;
    m_prev2 = m_prev1;
    m_prev1 = brdy_n;
    run = mtr && !trk_err;
    if (m_so_left > 0) m_so_left--;
    if (m_mode == M_IDLE) begin
      e_byte_rdy = 1'b0; e_sync_det = 1'b0; e_sync_wr = 1'b0;
      if (run) m_mode = mode_rd ? M_RD : M_ARM;
    end else begin
      flip = (mode_rd != (m_mode == M_RD));
      if (!run || flip) begin
        m_mode = M_IDLE; e_sync_wr = 1'b0; e_byte_rdy = 1'b0; e_sync_det = 1'b0;
        if (run) begin e_overrun = 1'b0; e_underrun = 1'b0; m_full = 1'b0; end
      end else if (m_mode == M_RD) begin
        if (bnd) begin
          e_rd_data  = byte_rd;
          e_sync_det = !sync_rd_n;
          if (sync_rd_n) begin
            if (e_byte_rdy && !cpu_rd) e_overrun = 1'b1;
            e_byte_rdy = 1'b1;
            m_so_left  = SO_WIDTH;
          end else if (cpu_rd) e_byte_rdy = 1'b0;
        end else if (cpu_rd) e_byte_rdy = 1'b0;
      end else begin
        take = bnd && (m_mode == M_WR || m_full || cpu_sync);
        if (take) begin
          m_mode    = M_WR;
          e_sync_wr = cpu_sync;
          if (m_full) begin
            e_byte_wr = m_hold; m_full = 1'b0; m_so_left = SO_WIDTH;
          end else begin
            e_byte_wr = FILL;
            if (!cpu_sync) e_underrun = 1'b1;
          end
        end
        if (cpu_wr) begin m_hold = cpu_din; m_full = 1'b1; end
        e_byte_rdy = !m_full;
      end
    end
    e_rw = !(m_mode == M_ARM || m_mode == M_WR);
  endtask

  // Model advances on the same edges as the DUT, including the asynchronous reset.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk_sys) begin
    if (so_prev && !so_n) so_falls++;
    so_prev = so_n;
    if (chk_en) begin
      chk("rw", rw, e_rw);
      chk("sync_wr", sync_wr, e_sync_wr);
      chk("byte_wr", byte_wr, e_byte_wr);
      chk("rd_data", rd_data, e_rd_data);
      chk("byte_rdy", byte_rdy, e_byte_rdy);
      chk("so_n", so_n, (m_so_left == 0));
      chk("sync_det", sync_det, e_sync_det);
      chk("overrun", overrun, e_overrun);
      chk("underrun", underrun, e_underrun);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // One byte boundary: brdy_n low for one cycle, byte held stable afterwards.
  task automatic send_byte(input logic [7:0] b, input logic sn);
    byte_rd = b; sync_rd_n = sn; brdy_n = 1'b0;
    tick(1);
    brdy_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse_rd();
    cpu_rd = 1'b1; tick(1); cpu_rd = 1'b0; tick(1);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    cpu_din = d; cpu_wr = 1'b1; tick(1); cpu_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t1_bytes [4];
  logic [7:0] r1, r2;
  int so_mark;
  int bcnt;

  initial begin
    t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0; mtr = 1'b0; mode_rd = 1'b1; brdy_n = 1'b1; sync_rd_n = 1'b1;
    byte_rd = 8'h00; trk_err = 1'b0; cpu_din = 8'h00; cpu_wr = 1'b0; cpu_sync = 1'b0;
    cpu_rd = 1'b0; bcnt = 0;
    tick(3);
    chk("rst_rw", rw, 1); chk("rst_byte_wr", byte_wr, 8'h00); chk("rst_so_n", so_n, 1);
    chk("rst_byte_rdy", byte_rdy, 0); chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Read four plain bytes, each consumed by the CPU.
    mtr = 1'b1;
    tick(3);
    chk("t1_state", 32'(state_dbg), 32'(S_RD));
    so_falls = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(t1_bytes[i], 1'b1);
      chk("t1_rd_data", rd_data, t1_bytes[i]);
      chk("t1_byte_rdy", byte_rdy, 1);
      pulse_rd();
      chk("t1_rdy_clr", byte_rdy, 0);
    end
    chk("t1_so_pulses", so_falls, 4);
    chk("t1_overrun", overrun, 0);

    // Two unconsumed bytes overrun; a mode round-trip clears the flag.
    r1 = 8'($urandom); r2 = 8'($urandom);
    send_byte(r1, 1'b1);
    send_byte(r2, 1'b1);
    chk("t2_rd_data", rd_data, r2);
    chk("t2_overrun", overrun, 1);
    mode_rd = 1'b0; tick(4);
    mode_rd = 1'b1; tick(4);
    chk("t2_overrun_clr", overrun, 0);

    // Sync field bytes are latched silently.
    so_mark = so_falls;
    for (int i = 0; i < 3; i++) send_byte(8'h42, 1'b0);
    chk("t3_sync_det", sync_det, 1);
    chk("t3_byte_rdy", byte_rdy, 0);
    chk("t3_no_so", so_falls, so_mark);
    send_byte(HEADER_SYNC_CODE, 1'b1);
    chk("t3_rdy_after", byte_rdy, 1);
    chk("t3_rd_data", rd_data, 8'h08);
    chk("t3_sync_det_off", sync_det, 0);
    pulse_rd();

    // Write two buffered bytes, then underrun on an empty boundary.
    mode_rd = 1'b0; tick(4);
    chk("t4_rw", rw, 0);
    chk("t4_free", byte_rdy, 1);
    pulse_wr(8'hA5);
    chk("t4_busy", byte_rdy, 0);
    send_byte(8'h00, 1'b1);
    chk("t4_wr_a5", byte_wr, 8'hA5);
    chk("t4_state", 32'(state_dbg), 32'(S_WR));
    pulse_wr(8'h5A);
    send_byte(8'h00, 1'b1);
    chk("t4_wr_5a", byte_wr, 8'h5A);
    chk("t4_no_underrun", underrun, 0);
    send_byte(8'h00, 1'b1);
    chk("t4_fill", byte_wr, 8'h00);
    chk("t4_underrun", underrun, 1);

    // Sync writing for three bytes, then a data byte.
    cpu_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00, 1'b1);
      chk("t5_sync_wr", sync_wr, 1);
    end
    cpu_sync = 1'b0;
    pulse_wr(DATA_SYNC_CODE);
    send_byte(8'h00, 1'b1);
    chk("t5_byte_wr", byte_wr, 8'h07);
    chk("t5_sync_off", sync_wr, 0);

    // Randomized traffic across both modes, motor drops and track errors.
    for (int c = 0; c < 2500; c++) begin
      mtr     = ($urandom_range(0, 299) != 0);
      trk_err = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) mode_rd = ~mode_rd;
      if ($urandom_range(0, 29) == 0)  cpu_sync = ~cpu_sync;
      cpu_wr  = ($urandom_range(0, 4) == 0);
      cpu_din = 8'($urandom);
      cpu_rd  = ($urandom_range(0, 3) == 0);
      if (bcnt == 0) begin
        brdy_n = 1'b0; byte_rd = 8'($urandom);
        sync_rd_n = ($urandom_range(0, 3) != 0);
        bcnt = $urandom_range(3, 8);
      end else begin
        brdy_n = 1'b1; bcnt--;
      end
      tick(1);
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_sync = 1'b0; mtr = 1'b1; trk_err = 1'b0; brdy_n = 1'b1;
    tick(3);

    // Asynchronous reset in the middle of writing.
    mode_rd = 1'b0; tick(4);
    pulse_wr(8'h3C);
    send_byte(8'h00, 1'b1);
    chk("t6_state_wr", 32'(state_dbg), 32'(S_WR));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rw", rw, 1); chk("t6_sync_wr", sync_wr, 0); chk("t6_byte_wr", byte_wr, 8'h00);
    chk("t6_rd_data", rd_data, 8'h00); chk("t6_byte_rdy", byte_rdy, 0); chk("t6_so_n", so_n, 1);
    chk("t6_sync_det", sync_det, 0); chk("t6_overrun", overrun, 0); chk("t6_underrun", underrun, 0);
    chk("t6_state", 32'(state_dbg), 32'(S_IDLE));
    tick(2);
    mode_rd = 1'b1; mtr = 1'b1; reset_n = 1'b1;
    tick(3);
    chk("t6_rd_state", 32'(state_dbg), 32'(S_RD));
    mtr = 1'b0; tick(2);
    chk("t6_mtr_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("t6_mtr_rw", rw, 1);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
